// File: rtl/tt_pkg.sv
// Purpose: shared constants and state encoding for the truth-table sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package tt_pkg;

    // Number of input vectors in one sweep and the width of the vector index.
    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;

    // Width of the settle down-counter; SETTLE_CYCLES is limited to 1..15.
    localparam int SETTLE_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Purpose: loadable down-counter timing how long each vector is held before sampling.
// Latency: expired rises SETTLE_CYCLES-1 enabled cycles after load (i.e. in the last hold cycle).
// Backpressure: none; counting is gated by en only.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   load       reload the counter (takes effect on the next edge)
//   en         decrement while the counter is non-zero
//   expired    counter is at zero: the current cycle is the last hold cycle
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    // Loading SETTLE_CYCLES-1 makes the zero count coincide with the final
    // hold cycle, so the caller moves on exactly SETTLE_CYCLES cycles after entry.
    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Purpose: sweeps all 16 {a,b,c,d} vectors into two external function units and records their truth tables.
// Latency: done pulses 16*(SETTLE_CYCLES+1) cycles after the edge that accepts start.
// Backpressure: start is ignored unless idle (no queuing); abort ends a sweep at the next edge.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, abort             sweep request (idle only) and sweep termination (busy only)
//   a, b, c, d               applied vector, a = MSB of index; zero when not sweeping
//   fn_x, fn_y               outputs of the NAND-form and NOR-form function units
//   busy, done               sweep in progress / one-cycle completion pulse
//   table_x, table_y         captured truth tables, bit i = function value at index i
//   mismatch_cnt             number of indices where fn_x != fn_y
//   first_mm_valid/_idx      lowest mismatching index, valid once any mismatch is seen
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             fn_x,
    input  logic             fn_y,
    output logic             busy,
    output logic             done,
    output logic [15:0]      table_x,
    output logic [15:0]      table_y,
    output logic [4:0]       mismatch_cnt,
    output logic             first_mm_valid,
    output logic [IDX_W-1:0] first_mm_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    tt_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       vec_q, vec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_VECTORS-1:0] tx_q, tx_d;
    logic [NUM_VECTORS-1:0] ty_q, ty_d;
    logic [4:0]             mm_cnt_q, mm_cnt_d;
    logic                   fmv_q, fmv_d;
    logic [IDX_W-1:0]       fmi_q, fmi_d;

    logic                   timer_load;
    logic                   timer_en;
    logic                   timer_expired;

    // The timer is reloaded on every entry into APPLY (from IDLE or SAMPLE)
    // and only runs while a vector is being held.
    assign timer_load = (state_d == ST_APPLY) && (state_q != ST_APPLY);
    assign timer_en   = (state_q == ST_APPLY);

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        mm_cnt_d = mm_cnt_q;
        fmv_d    = fmv_q;
        fmi_d    = fmi_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    idx_d    = '0;
                    tx_d     = '0;
                    ty_d     = '0;
                    mm_cnt_d = '0;
                    fmv_d    = 1'b0;
                    fmi_d    = '0;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                // abort wins over the capture: partial results stay as they were.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_d[idx_q] = fn_x;
                    ty_d[idx_q] = fn_y;
                    if (fn_x != fn_y) begin
                        // At most 16 increments per sweep, so 5 bits never wrap.
                        mm_cnt_d = mm_cnt_q + 5'd1;
                        if (!fmv_q) begin
                            fmv_d = 1'b1;
                            fmi_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        // The vector stays applied through SAMPLE so the units are still settled.
        busy_d = (state_d == ST_APPLY) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        vec_d  = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tx_q     <= '0;
            ty_q     <= '0;
            mm_cnt_q <= '0;
            fmv_q    <= 1'b0;
            fmi_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            mm_cnt_q <= mm_cnt_d;
            fmv_q    <= fmv_d;
            fmi_q    <= fmi_d;
        end
    end

    assign {a, b, c, d}   = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign table_x        = tx_q;
    assign table_y        = ty_q;
    assign mismatch_cnt   = mm_cnt_q;
    assign first_mm_valid = fmv_q;
    assign first_mm_idx   = fmi_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Purpose: checks three sequencer instances (hold 2, 1 and 15 cycles) against a sweep-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_i   = 3'b111;
    logic [2:0] start_i = 3'b000;
    logic [2:0] abort_i = 3'b000;
    int         fn_mode [3] = '{0, 0, 0};

    logic [2:0] a_w, b_w, c_w, d_w, fnx_w, fny_w, busy_w, done_w, fv_w;
    logic [15:0] tx_w [3];
    logic [15:0] ty_w [3];
    logic [4:0]  cnt_w [3];
    logic [3:0]  fi_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        truth_table_sequencer #(.SETTLE_CYCLES(S)) u_dut (
            .clk            (clk),
            .rst            (rst_i[g]),
            .start          (start_i[g]),
            .abort          (abort_i[g]),
            .a              (a_w[g]),
            .b              (b_w[g]),
            .c              (c_w[g]),
            .d              (d_w[g]),
            .fn_x           (fnx_w[g]),
            .fn_y           (fny_w[g]),
            .busy           (busy_w[g]),
            .done           (done_w[g]),
            .table_x        (tx_w[g]),
            .table_y        (ty_w[g]),
            .mismatch_cnt   (cnt_w[g]),
            .first_mm_valid (fv_w[g]),
            .first_mm_idx   (fi_w[g])
        );
        // Function-unit stubs: fn_x = a^d always; fn_y chosen by fn_mode.
        assign fnx_w[g] = a_w[g] ^ d_w[g];
        assign fny_w[g] = (fn_mode[g] == 0) ? (a_w[g] ^ d_w[g]) :
                          (fn_mode[g] == 1) ? 1'b0 : (b_w[g] & ~c_w[g]);
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got 0x%0h, expected 0x%0h", nm, g, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int settle_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    endfunction

    function automatic bit fx(input int i);
        return bit'(i[3] ^ i[0]);
    endfunction

    function automatic bit fy(input int mode, input int i);
        if (mode == 0) return fx(i);
        if (mode == 1) return 1'b0;
        return bit'(i[2] & ~i[1]);
    endfunction

    // phase: 0 idle, 1 sweeping, 2 done; cyc = cycles elapsed since the accepting edge.
    int          m_phase [3] = '{0, 0, 0};
    int          m_cyc   [3] = '{0, 0, 0};
    logic [15:0] m_tx    [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m_ty    [3] = '{16'h0, 16'h0, 16'h0};
    int          m_cnt   [3] = '{0, 0, 0};
    bit          m_fv    [3] = '{1'b0, 1'b0, 1'b0};
    int          m_fi    [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            int s, v;
            bit bx, by;
            s = settle_of(g);
            if (rst_i[g]) begin
                m_phase[g] = 0; m_cyc[g] = 0; m_tx[g] = '0; m_ty[g] = '0;
                m_cnt[g] = 0; m_fv[g] = 1'b0; m_fi[g] = 0;
            end else begin
                case (m_phase[g])
                    0: if (start_i[g]) begin
                        m_phase[g] = 1; m_cyc[g] = 0; m_tx[g] = '0; m_ty[g] = '0;
                        m_cnt[g] = 0; m_fv[g] = 1'b0; m_fi[g] = 0;
                    end
                    1: if (abort_i[g]) begin
                        m_phase[g] = 0;
                    end else begin
                        v = m_cyc[g] / (s + 1);
                        if (m_cyc[g] % (s + 1) == s) begin
                            bx = fx(v);
                            by = fy(fn_mode[g], v);
                            m_tx[g][v] = bx;
                            m_ty[g][v] = by;
                            if (bx != by) begin
                                m_cnt[g]++;
                                if (!m_fv[g]) begin m_fv[g] = 1'b1; m_fi[g] = v; end
                            end
                            if (v == 15) m_phase[g] = 2;
                        end
                        m_cyc[g]++;
                    end
                    default: m_phase[g] = 0;
                endcase
            end
        end
    end

    // Single compare process: every instance, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int g = 0; g < 3; g++) begin
                logic [3:0] vec;
                int ev;
                vec = {a_w[g], b_w[g], c_w[g], d_w[g]};
                ev  = (m_phase[g] == 1) ? m_cyc[g] / (settle_of(g) + 1) : 0;
                chk("vec",   g, 32'(vec),        32'(ev));
                chk("busy",  g, 32'(busy_w[g]),  32'(m_phase[g] == 1));
                chk("done",  g, 32'(done_w[g]),  32'(m_phase[g] == 2));
                chk("tx",    g, 32'(tx_w[g]),    32'(m_tx[g]));
                chk("ty",    g, 32'(ty_w[g]),    32'(m_ty[g]));
                chk("mmcnt", g, 32'(cnt_w[g]),   32'(m_cnt[g]));
                chk("fmv",   g, 32'(fv_w[g]),    32'(m_fv[g]));
                chk("fmi",   g, 32'(fi_w[g]),    32'(m_fi[g]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Pulse start on instance g and count edges from acceptance to done.
    task automatic run_sweep(input int g, input int exp_lat);
        int lat;
        @(negedge clk) start_i[g] = 1'b1;
        @(posedge clk);
        @(negedge clk) start_i[g] = 1'b0;
        lat = 0;
        while (!done_w[g] && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("done_latency", g, 32'(lat), 32'(exp_lat));
    endtask

    task automatic accept_start(input int g);
        @(negedge clk) start_i[g] = 1'b1;
        @(posedge clk);
        @(negedge clk) start_i[g] = 1'b0;
    endtask

    initial begin
        int pulses, n;
        repeat (3) @(posedge clk);
        check_en = 1'b1;
        @(negedge clk) rst_i = 3'b000;
        // Reset state pinned with literals.
        chk("rst_tx", 0, 32'(tx_w[0]), 32'h0);
        chk("rst_busy", 0, 32'(busy_w[0]), 32'h0);
        chk("rst_vec", 0, 32'({a_w[0], b_w[0], c_w[0], d_w[0]}), 32'h0);

        // Identical units: 16'h55AA both, no mismatch.
        run_sweep(0, 48);
        chk("m0_tx", 0, 32'(tx_w[0]), 32'h55AA);
        chk("m0_ty", 0, 32'(ty_w[0]), 32'h55AA);
        chk("m0_cnt", 0, 32'(cnt_w[0]), 32'd0);
        chk("m0_fmv", 0, 32'(fv_w[0]), 32'd0);

        // fn_y stuck at 0.
        @(negedge clk) fn_mode[0] = 1;
        run_sweep(0, 48);
        chk("m1_ty", 0, 32'(ty_w[0]), 32'h0000);
        chk("m1_cnt", 0, 32'(cnt_w[0]), 32'd8);
        chk("m1_fmi", 0, 32'(fi_w[0]), 32'd1);
        repeat (4) @(negedge clk);
        chk("m1_hold_cnt", 0, 32'(cnt_w[0]), 32'd8);

        // fn_y = b & ~c: table 0x3030, xor with 0x55AA = 0x659A.
        @(negedge clk) fn_mode[0] = 2;
        run_sweep(0, 48);
        chk("m2_ty", 0, 32'(ty_w[0]), 32'h3030);
        chk("m2_cnt", 0, 32'(cnt_w[0]), 32'd8);
        chk("m2_fmi", 0, 32'(fi_w[0]), 32'd1);

        // abort while idle has no effect.
        @(negedge clk) abort_i[0] = 1'b1;
        @(negedge clk) abort_i[0] = 1'b0;
        chk("idle_abort_busy", 0, 32'(busy_w[0]), 32'd0);

        // start held high through the sweep and through DONE.
        @(negedge clk) begin fn_mode[0] = 0; start_i[0] = 1'b1; end
        pulses = 0;
        n = 0;
        while (!done_w[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("hold_start_done_seen", 0, 32'(done_w[0]), 32'd1);
        chk("done_cycle_busy", 0, 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        chk("after_done_busy", 0, 32'(busy_w[0]), 32'd0);
        start_i[0] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (done_w[0]) pulses++;
            @(negedge clk);
        end
        chk("no_extra_done", 0, 32'(pulses), 32'd0);

        // abort in the SAMPLE cycle of idx 5 (cycle 5*3+2 = 17 after acceptance).
        accept_start(0);
        repeat (17) @(negedge clk);
        chk("pre_abort_vec", 0, 32'({a_w[0], b_w[0], c_w[0], d_w[0]}), 32'd5);
        abort_i[0] = 1'b1;
        @(negedge clk) abort_i[0] = 1'b0;
        chk("abort_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("abort_tx", 0, 32'(tx_w[0]), 32'h000A);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            if (done_w[0]) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", 0, 32'(pulses), 32'd0);
        chk("abort_hold_tx", 0, 32'(tx_w[0]), 32'h000A);

        // Reset during APPLY of idx 9 (cycle 27), after a full sweep left results.
        run_sweep(0, 48);
        accept_start(0);
        repeat (27) @(negedge clk);
        chk("pre_rst_vec", 0, 32'({a_w[0], b_w[0], c_w[0], d_w[0]}), 32'd9);
        rst_i[0] = 1'b1;
        @(negedge clk) rst_i[0] = 1'b0;
        chk("rst_mid_tx", 0, 32'(tx_w[0]), 32'h0);
        chk("rst_mid_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("rst_mid_vec", 0, 32'({a_w[0], b_w[0], c_w[0], d_w[0]}), 32'd0);
        run_sweep(0, 48);
        chk("post_rst_tx", 0, 32'(tx_w[0]), 32'h55AA);

        // Other hold lengths.
        run_sweep(1, 32);
        chk("s1_tx", 1, 32'(tx_w[1]), 32'h55AA);
        run_sweep(2, 256);
        chk("s15_tx", 2, 32'(tx_w[2]), 32'h55AA);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each input vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request one full 16-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep; sampled in APPLY/SAMPLE.
REQ-006 a, b, c, d  output  1 each  vector driven to both function units; index i = {a,b,c,d}, a = MSB.
REQ-007 fn_x  input  1  output of NAND-form function unit.
REQ-008 fn_y  input  1  output of NOR-form function unit.
REQ-009 busy  output  1  high in APPLY and SAMPLE.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 table_x, table_y  output  16 each  captured truth tables; bit i = fn value at index i.
REQ-012 mismatch_cnt  output  5  number of indices with fn_x != fn_y (0..16).
REQ-013 first_mm_valid  output  1  at least one mismatch recorded.
REQ-014 first_mm_idx  output  4  lowest index with a mismatch; 0 when first_mm_valid = 0.

Function
REQ-015 FSM states: IDLE, APPLY, SAMPLE, DONE; these four only.
REQ-016 IDLE: start = 1 -> APPLY, with idx = 0, settle count = 0, tables, mismatch_cnt, first_mm_* cleared on the same edge.
REQ-017 APPLY: {a,b,c,d} = idx; remains SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-018 SAMPLE (1 cycle): table_x[idx] <= fn_x, table_y[idx] <= fn_y; if fn_x != fn_y, mismatch_cnt increments and, if first_mm_valid = 0, first_mm_idx <= idx and first_mm_valid <= 1.
REQ-019 SAMPLE with idx = 15 -> DONE; otherwise idx increments and -> APPLY; idx never wraps within a sweep.
REQ-020 DONE (1 cycle): done = 1, then -> IDLE unconditionally.
REQ-021 Latency: DONE entered exactly 16*(SETTLE_CYCLES+1) cycles after the edge at which start is accepted.
REQ-022 start while busy or in DONE is ignored; no queuing.
REQ-023 abort in APPLY or SAMPLE -> IDLE next edge; no done pulse; abort has priority over any same-cycle SAMPLE capture; results captured so far are held.
REQ-024 abort in IDLE or DONE is ignored.
REQ-025 {a,b,c,d} = 4'b0000 in IDLE and DONE.
REQ-026 All results hold their values from DONE until the next accepted start.
REQ-027 mismatch_cnt is 5 bits and cannot overflow (max 16).

Reset
REQ-028 rst = 1 at a rising edge forces IDLE, idx = 0, settle count = 0, a = b = c = d = 0, busy = 0, done = 0, table_x = table_y = 16'h0000, mismatch_cnt = 0, first_mm_valid = 0, first_mm_idx = 0.
REQ-029 rst overrides start and abort; rst mid-sweep discards all partial results and does not pulse done.

Structure
REQ-030 Shared package tt_pkg holds the state enumeration, NUM_VECTORS = 16 and IDX_W = 4.
REQ-031 One sub-module, tt_settle_timer: loadable down-counter that signals expiry after SETTLE_CYCLES cycles.
REQ-032 The function units are instantiated outside this block; the sequencer contains no function logic.

Verification
REQ-033 SETTLE_CYCLES = 2, stub fn_x = fn_y = a^d, start pulse -> done exactly 48 cycles later, table_x = table_y = 16'h55AA, mismatch_cnt = 0, first_mm_valid = 0.
REQ-034 Stub fn_x = a^d, fn_y = 0 -> table_x = 16'h55AA, table_y = 16'h0000, mismatch_cnt = 8, first_mm_idx = 1.
REQ-035 start held high through a sweep and asserted again during DONE -> exactly one done pulse, busy low in the DONE cycle, next sweep begins only from IDLE.
REQ-036 abort during SAMPLE of idx = 5 -> IDLE next cycle, no done, table_x[15:5] = 0, bits 4:0 hold captured values.
REQ-037 rst asserted during APPLY of idx = 9 -> all outputs at reset values (REQ-028) on the next cycle; a subsequent start gives a correct full sweep.
REQ-038 SETTLE_CYCLES = 1 and 15 -> done latency 32 and 256 cycles, with each vector held 1 and 15 cycles before sampling.
